adpll_loop_filter: RTL and testbench

Digital proportional-integral loop filter for the all-digital PLL. It takes the signed phase/frequency error from the phase detector once per generated-clock cycle and produces the unsigned control code that steers the DCO. It sits between the phase detector and the DCO.

---
 rtl/adpll_pkg.sv | 40 ++++
 rtl/adpll_loop_filter_if.sv | 31 +++
 rtl/adpll_loop_filter_integrator.sv | 46 ++++
 rtl/adpll_loop_filter.sv | 76 +++++++
 tb/tb_adpll_loop_filter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/adpll_pkg.sv
// ---------------------------------------------------------------------------
// adpll_pkg
// Shared constants, types and helpers for the ADPLL loop filter.
//   ERR_W / CC_W    : phase-error and DCO control-code widths
//   error_t         : signed phase error from the phase detector
//   dco_cc_t        : unsigned DCO control code
//   CC_CENTER_DEF   : default DCO code at reset / zero correction
//   sat_range()     : generic signed saturate, used by the integrator clamp
//                     and by the output clamp
// ---------------------------------------------------------------------------
package adpll_pkg;

    localparam int ERR_W         = 8;
    localparam int CC_W          = 8;
    localparam int CC_CENTER_DEF = 128;

    typedef logic signed [ERR_W-1:0] error_t;
    typedef logic        [CC_W-1:0]  dco_cc_t;

    // Output code limits expressed in the wide signed domain of sat_range().
    localparam logic signed [63:0] CC_LO = 64'sd0;
    localparam logic signed [63:0] CC_HI = 64'sd255;

    // Clamp a wide signed value into [lo, hi]. Callers sign-extend into
    // 64 bits first so any ACC_W up to 62 fits without overflow.
    function automatic logic signed [63:0] sat_range(
        input logic signed [63:0] v,
        input logic signed [63:0] lo,
        input logic signed [63:0] hi
    );
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/adpll_loop_filter_if.sv
// ---------------------------------------------------------------------------
// adpll_loop_filter_if
// Groups the loop-filter data path signals.
//   error_i   : signed phase error, driven by the phase detector (master)
//   dco_cc_o  : registered DCO control code, driven by the filter (slave)
//   acc_dbg_o : registered integrator state, observation only
// No handshake: error_i is sampled on every rising gen_clk_i edge and
// dco_cc_o is valid in every cycle (one registered update per edge).
// ---------------------------------------------------------------------------
interface adpll_loop_filter_if #(
    parameter int ACC_W = 16
);
    import adpll_pkg::*;

    error_t                   error_i;
    dco_cc_t                  dco_cc_o;
    logic signed [ACC_W-1:0]  acc_dbg_o;

    modport master (
        output error_i,
        input  dco_cc_o,
        input  acc_dbg_o
    );

    modport slave (
        input  error_i,
        output dco_cc_o,
        output acc_dbg_o
    );

endinterface

// File: rtl/adpll_loop_filter_integrator.sv
// ---------------------------------------------------------------------------
// loop_filter_integrator
// Saturating signed accumulator of the phase error (no wrap, no anti-windup).
//   gen_clk_i  : generated clock, rising-edge update
//   reset_i    : asynchronous active-high reset, clears the accumulator
//   error_i    : signed phase error
//   acc_next_o : combinational next accumulator value (feeds the integral term)
//   acc_o      : registered accumulator
// ---------------------------------------------------------------------------
module loop_filter_integrator
    import adpll_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic                    gen_clk_i,
    input  logic                    reset_i,
    input  error_t                  error_i,
    output logic signed [ACC_W-1:0] acc_next_o,
    output logic signed [ACC_W-1:0] acc_o
);

    localparam logic signed [63:0] ACC_MAX = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
    localparam logic signed [63:0] ACC_MIN = -ACC_MAX - 64'sd1;

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W:0]   sum_w;

    always_comb begin
        // One guard bit is enough: |error| <= 128 cannot overflow ACC_W+1 bits.
        sum_w = (ACC_W + 1)'(acc_q) + (ACC_W + 1)'(error_i);
        acc_d = ACC_W'(sat_range(64'(sum_w), ACC_MIN, ACC_MAX));
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_next_o = acc_d;
    assign acc_o      = acc_q;

endmodule

// File: rtl/adpll_loop_filter.sv
// ---------------------------------------------------------------------------
// adpll_loop_filter
// Proportional-integral loop filter between the phase detector and the DCO.
//   gen_clk_i : generated clock, all state updates on its rising edge
//   reset_i   : asynchronous active-high reset (acc = 0, dco_cc_o = CC_CENTER)
//   lf        : adpll_loop_filter_if.slave (error_i in, dco_cc_o / acc_dbg_o out)
// Parameters: ACC_W (integrator width), KP_SHIFT / KI_SHIFT (gains as
// arithmetic right shifts), CC_CENTER (DCO code with zero correction).
// Build option: LOOP_FILTER_PROP_EN defined -> full PI filter;
// undefined -> proportional path removed, integral-only filter.
// dco_cc_o = clamp(CC_CENTER + (error >>> KP_SHIFT) + (acc_next >>> KI_SHIFT)),
// registered, one cycle latency.
// ---------------------------------------------------------------------------
module adpll_loop_filter
    import adpll_pkg::*;
#(
    parameter int ACC_W     = 16,
    parameter int KP_SHIFT  = 1,
    parameter int KI_SHIFT  = 4,
    parameter int CC_CENTER = CC_CENTER_DEF
) (
    input  logic               gen_clk_i,
    input  logic               reset_i,
    adpll_loop_filter_if.slave lf
);

`ifdef LOOP_FILTER_PROP_EN
    localparam error_t PROP_MASK = '1;
`else
    // All-zero mask removes the proportional path entirely.
    localparam error_t PROP_MASK = '0;
`endif

    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc;
    error_t                  p_raw;
    error_t                  p_term;
    logic signed [ACC_W-1:0] i_term;
    logic signed [ACC_W+1:0] sum;
    dco_cc_t                 dco_cc_q;
    dco_cc_t                 dco_cc_d;

    loop_filter_integrator #(
        .ACC_W (ACC_W)
    ) u_integrator (
        .gen_clk_i  (gen_clk_i),
        .reset_i    (reset_i),
        .error_i    (lf.error_i),
        .acc_next_o (acc_next),
        .acc_o      (acc)
    );

    always_comb begin
        // Shifts are done on signed operands on their own so they stay
        // arithmetic (round toward -inf); masking comes afterwards.
        p_raw  = lf.error_i >>> KP_SHIFT;
        p_term = p_raw & PROP_MASK;
        i_term = acc_next >>> KI_SHIFT;
        sum    = (ACC_W + 2)'(CC_CENTER) + (ACC_W + 2)'(p_term) + (ACC_W + 2)'(i_term);
        // Output clamp is independent of the integrator clamp: the
        // accumulator keeps integrating while the code sits on a rail.
        dco_cc_d = CC_W'(sat_range(64'(sum), CC_LO, CC_HI));
    end

    always_ff @(posedge gen_clk_i or posedge reset_i) begin
        if (reset_i) begin
            dco_cc_q <= CC_W'(CC_CENTER);
        end else begin
            dco_cc_q <= dco_cc_d;
        end
    end

    assign lf.dco_cc_o  = dco_cc_q;
    assign lf.acc_dbg_o = acc;

endmodule

// File: tb/tb_adpll_loop_filter.sv
module tb_adpll_loop_filter;
  import adpll_pkg::*;

  // ---------------- clock / reset ----------------
  logic gen_clk_i = 1'b0;
  logic reset_i   = 1'b0;
  always #5 gen_clk_i = ~gen_clk_i;

  adpll_loop_filter_if #(.ACC_W(16)) lf ();

  adpll_loop_filter #(
    .ACC_W     (16),
    .KP_SHIFT  (1),
    .KI_SHIFT  (4),
    .CC_CENTER (128)
  ) dut (
    .gen_clk_i (gen_clk_i),
    .reset_i   (reset_i),
    .lf        (lf)
  );

`ifdef LOOP_FILTER_PROP_EN
  localparam bit PROP = 1'b1;
`else
  localparam bit PROP = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  logic [23:0] exp_q[$];   // {acc[15:0], dco[7:0]}
  int checks   = 0;
  int failures = 0;
  int vec_idx  = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: one registered result per rising edge, sampled on the falling edge.
  always @(negedge gen_clk_i) begin
    if (exp_q.size() > 0) begin
      logic [23:0] e;
      e = exp_q.pop_front();
      vec_idx++;
      check($sformatf("dco[%0d]", vec_idx), int'(lf.dco_cc_o), int'(e[7:0]));
      check($sformatf("acc[%0d]", vec_idx), int'($signed(lf.acc_dbg_o)), int'($signed(e[23:8])));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int err, input int exp_dco, input int exp_acc);
    @(negedge gen_clk_i);
    #1;
    lf.error_i = 8'(err);
    exp_q.push_back({16'(exp_acc), 8'(exp_dco)});
  endtask

  task automatic drain();
    repeat (2) @(negedge gen_clk_i);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Reset pulse placed between edges; state must clear without a clock edge.
  task automatic reset_pulse(input string name);
    drain();
    lf.error_i = 8'sd0;
    reset_i = 1'b1;
    #1;
    check({name, "_dco"}, int'(lf.dco_cc_o), 128);
    check({name, "_acc"}, int'($signed(lf.acc_dbg_o)), 0);
    #1;
    reset_i = 1'b0;
  endtask

  // Reference behaviour for the long saturation run.
  function automatic int model_dco(input int acc, input int err);
    int p;
    int s;
    p = PROP ? (err >>> 1) : 0;
    s = 128 + p + (acc >>> 4);
    if (s < 0)   s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic sat_run(input int err, input int n, inout int acc);
    for (int k = 0; k < n; k++) begin
      acc = acc + err;
      if (acc > 32767)  acc = 32767;
      if (acc < -32768) acc = -32768;
      step(err, model_dco(acc, err), acc);
    end
  endtask

  // ---------------- directed vectors ----------------
  int pos_dco [5];
  int neg_dco [4];
  int zero_dco[2];
  int mid_dco [4];

  initial begin
    int acc_m;
    lf.error_i = 8'sd0;
    if (PROP) begin
      pos_dco  = '{133, 134, 134, 135, 136};
      zero_dco = '{131, 131};
      neg_dco  = '{122, 121, 121, 120};
      mid_dco  = '{133, 134, 134, 133};
    end else begin
      pos_dco  = '{128, 129, 129, 130, 131};
      zero_dco = '{131, 131};
      neg_dco  = '{127, 126, 126, 125};
      mid_dco  = '{128, 129, 129, 128};
    end

    // Reset takes effect before any clock edge and holds under toggling clock.
    #2;
    reset_i = 1'b1;
    #1;
    check("rst_async_dco", int'(lf.dco_cc_o), 128);
    check("rst_async_acc", int'($signed(lf.acc_dbg_o)), 0);
    lf.error_i = 8'sd50;
    for (int k = 0; k < 4; k++) begin
      @(negedge gen_clk_i);
      check($sformatf("rst_hold_dco[%0d]", k), int'(lf.dco_cc_o), 128);
      check($sformatf("rst_hold_acc[%0d]", k), int'($signed(lf.acc_dbg_o)), 0);
    end
    #1;
    lf.error_i = 8'sd0;
    reset_i = 1'b0;

    // +10 from reset release, first edge is a normal update.
    for (int k = 0; k < 5; k++) step(10, pos_dco[k], 10 * (k + 1));
    // Zero error holds the accumulator.
    for (int k = 0; k < 2; k++) step(0, zero_dco[k], 50);

    // -10 from reset.
    reset_pulse("rst_b");
    for (int k = 0; k < 4; k++) step(-10, neg_dco[k], -10 * (k + 1));

    // Mid-run reset between edges.
    reset_pulse("rst_c");
    for (int k = 0; k < 3; k++) step(10, mid_dco[k], 10 * (k + 1));
    reset_pulse("mid_rst");
    step(10, mid_dco[3], 10);

    // Saturation: both rails, independent output clamp, no anti-windup.
    reset_pulse("rst_d");
    acc_m = 0;
    sat_run(127, 300, acc_m);
    drain();
    check("acc_pos_rail", int'($signed(lf.acc_dbg_o)), 32767);
    check("dco_pos_rail", int'(lf.dco_cc_o), 255);
    sat_run(-128, 560, acc_m);
    drain();
    check("acc_neg_rail", int'($signed(lf.acc_dbg_o)), -32768);
    check("dco_neg_rail", int'(lf.dco_cc_o), 0);
    sat_run(127, 20, acc_m);

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
